// File: rtl/program_counter_pkg.sv
// Shared defaults for the program counter: width, reset value and increment step.
package program_counter_pkg;

    localparam int              DEFAULT_WIDTH       = 16;
    localparam logic [15:0]     DEFAULT_RESET_VALUE = 16'h0000;
    localparam int              DEFAULT_INC_STEP    = 1;

endpackage : program_counter_pkg

// File: rtl/program_counter_next.sv
// Next-value logic for the program counter: load beats increment, increment wraps modulo 2^WIDTH.
module program_counter_next
    import program_counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int INC_STEP = DEFAULT_INC_STEP
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             load_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] nxt_o
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(INC_STEP);

    // Truncating add gives the modulo wrap with no carry out.
    always_comb begin
        nxt_o = cur_i;
        if (load_i) begin
            nxt_o = in_i;
        end else if (inc_i) begin
            nxt_o = cur_i + STEP;
        end
    end

endmodule : program_counter_next

// File: rtl/program_counter.sv
// Program counter register with async active-low reset; next value comes from program_counter_next.
// Define PROGRAM_COUNTER_ASSERT_EN to compile in simulation-only X/reset checks.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE),
    parameter int               INC_STEP    = DEFAULT_INC_STEP
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    program_counter_next #(
        .WIDTH    (WIDTH),
        .INC_STEP (INC_STEP)
    ) u_next (
        .cur_i  (cnt_q),
        .in_i   (in),
        .load_i (load),
        .inc_i  (inc),
        .nxt_o  (cnt_d)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RESET_VALUE;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out = cnt_q;

`ifdef PROGRAM_COUNTER_ASSERT_EN
    always @(posedge clock) begin
        if (rst_n && $isunknown({load, inc, in})) begin
            $error("program_counter: X/Z on load/inc/in at rising edge");
        end
    end

    // Sampled on the falling edge so the async reset has settled.
    always @(negedge clock) begin
        if (!rst_n && (out !== RESET_VALUE)) begin
            $error("program_counter: out %h not at reset value during reset", out);
        end
    end
`else
`endif

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: vector table plus scoreboard, then reset corner cases.
module tb_program_counter;

    logic        clock;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic        inc;
    logic [15:0] out;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic        ld;
        logic        ic;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    program_counter dut (
        .clock (clock),
        .rst_n (rst_n),
        .in    (in),
        .load  (load),
        .inc   (inc),
        .out   (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, out=%h", out);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, record expectation, compare just after the rising edge.
    task automatic cycle(input string name, input logic ld, input logic ic,
                         input logic [15:0] din, input logic [15:0] exp);
        logic [15:0] e;
        @(negedge clock);
        load = ld;
        inc  = ic;
        in   = din;
        exp_q.push_back(exp);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %h expected entry", name, out);
        end else begin
            e = exp_q.pop_front();
            check(name, out, e);
        end
    endtask

    initial begin
        logic [15:0] model;
        logic        rl, ri;
        logic [15:0] rd;

        rst_n = 1'b0;
        load  = 1'b0;
        inc   = 1'b0;
        in    = 16'h0000;
        #3;
        check("reset_state", out, 16'h0000);

        @(negedge clock);
        rst_n = 1'b1;
        cycle("release_hold", 1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle("release_inc",  1'b0, 1'b1, 16'h0000, 16'h0001);

        vecs.push_back('{1'b1, 1'b0, 16'hABCD, 16'hABCD});
        vecs.push_back('{1'b0, 1'b0, 16'h1111, 16'hABCD});
        vecs.push_back('{1'b0, 1'b0, 16'h2222, 16'hABCD});
        vecs.push_back('{1'b0, 1'b0, 16'h3333, 16'hABCD});
        vecs.push_back('{1'b1, 1'b0, 16'h0005, 16'h0005});
        vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'h0006});
        vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'h0007});
        vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'h0008});
        vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'h0009});
        vecs.push_back('{1'b1, 1'b0, 16'hFFFE, 16'hFFFE});
        vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'hFFFF});
        vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'h0001});
        vecs.push_back('{1'b1, 1'b0, 16'h0050, 16'h0050});
        vecs.push_back('{1'b1, 1'b1, 16'h0100, 16'h0100});
        vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'h0101});
        vecs.push_back('{1'b1, 1'b0, 16'h1234, 16'h1234});

        foreach (vecs[i]) begin
            cycle($sformatf("vec%0d", i), vecs[i].ld, vecs[i].ic, vecs[i].din, vecs[i].exp);
        end

        // Falling edge and mid-cycle input changes must not move out.
        @(negedge clock);
        #1;
        check("negedge_hold", out, 16'h1234);
        load = 1'b1;
        inc  = 1'b1;
        in   = 16'h5A5A;
        #2;
        check("midcycle_inputs", out, 16'h1234);
        load = 1'b0;
        inc  = 1'b0;

        // Async reset mid-cycle with out=1234, then inc held high under reset.
        @(posedge clock);
        #3;
        check("pre_reset", out, 16'h1234);
        rst_n = 1'b0;
        #1;
        check("async_reset", out, 16'h0000);
        inc = 1'b1;
        load = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
            check("reset_holds_inc", out, 16'h0000);
        end
        @(negedge clock);
        load = 1'b1;
        in   = 16'hBEEF;
        @(posedge clock);
        #1;
        check("reset_holds_load", out, 16'h0000);

        @(negedge clock);
        load  = 1'b0;
        inc   = 1'b0;
        rst_n = 1'b1;
        cycle("release2_hold", 1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle("release2_inc",  1'b0, 1'b1, 16'h0000, 16'h0001);

        // Random traffic against a simple priority model.
        model = 16'h0001;
        for (int k = 0; k < 200; k++) begin
            rl = ($urandom_range(0, 3) == 0);
            ri = ($urandom_range(0, 1) == 1);
            rd = 16'($urandom);
            if (k % 50 == 0) rd = 16'hFFFF;
            if (rl)      model = rd;
            else if (ri) model = model + 16'd1;
            cycle("random", rl, ri, rd, model);
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_program_counter
